// File: rtl/rv523_pc_pkg.sv
// Shared definitions for the RV523 program-counter sequencer.
// Holds the sequencer state encoding and the default PC width, reset
// vector and fetch increment used by pc_fetch_seq and pc_inc.
package rv523_pc_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam int          INC_DEF       = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_REQ  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_inc.sv
// Structural PC incrementer: adds INC (a power of two >= 4) to a word-aligned
// PC as a ripple chain of half adders starting at bit log2(INC). Bits below
// that position pass through unchanged. The carry out of the top bit is
// dropped, so the sum wraps modulo 2^XLEN.
// Ports:
//   i_a   [XLEN-1:0]  PC in
//   o_sum [XLEN-1:0]  PC + INC
module pc_ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module pc_inc
    import rv523_pc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int INC  = INC_DEF
) (
    input  logic [XLEN-1:0] i_a,
    output logic [XLEN-1:0] o_sum
);
    localparam int LSB = $clog2(INC);

    logic [XLEN-1:LSB] w_carry;

    // Adding a single power of two is a constant carry-in at bit LSB.
    assign w_carry[LSB]     = 1'b1;
    assign o_sum[LSB-1:0]   = i_a[LSB-1:0];

    genvar g;
    generate
        for (g = LSB; g < XLEN - 1; g++) begin : g_ha
            pc_ha u_ha (
                .i_a (i_a[g]),
                .i_b (w_carry[g]),
                .o_s (o_sum[g]),
                .o_c (w_carry[g+1])
            );
        end
    endgenerate

    // Top bit needs no carry out: the wrap past 2^XLEN is silent.
    assign o_sum[XLEN-1] = i_a[XLEN-1] ^ w_carry[XLEN-1];

endmodule

// File: rtl/pc_fetch_seq.sv
// Program-counter sequencer for the RV523 core. Holds the PC, issues fetch
// requests with a REQ/ACK handshake, parks redirects that arrive while a
// request is outstanding, and flags the acked fetch as wrong-path (SQUASH)
// when a redirect overtakes it.
// Ports:
//   CLK        clock, rising edge
//   RN         asynchronous active-low reset
//   STALL      blocks raising a new request; never drops an outstanding one
//   REDIR      one-cycle redirect strobe
//   REDIR_ADDR redirect target, bits [1:0] ignored
//   REQ        fetch request valid
//   ADDR       fetch address (current PC)
//   ACK        fetch stage accepted ADDR this cycle (only while REQ=1)
//   SQUASH     one-cycle pulse: previous-cycle acked fetch is wrong-path
module pc_fetch_seq
    import rv523_pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int              INC       = INC_DEF
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            STALL,
    input  logic            REDIR,
    input  logic [XLEN-1:0] REDIR_ADDR,
    output logic            REQ,
    output logic [XLEN-1:0] ADDR,
    input  logic            ACK,
    output logic            SQUASH
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'd3));
    localparam logic [XLEN-1:0] RESET_PC   = RESET_VEC & ALIGN_MASK;

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_redir_addr;
    logic            r_pend_valid;
    logic            w_pend_valid_nxt;
    logic [XLEN-1:0] r_pend_addr;
    logic [XLEN-1:0] w_pend_addr_nxt;
    logic            r_squash;
    logic            w_squash_nxt;

    assign w_redir_addr = REDIR_ADDR & ALIGN_MASK;

    pc_inc #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_pc_inc (
        .i_a   (r_pc),
        .o_sum (w_pc_inc)
    );

    // State register.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: BOOT lasts one cycle; a request holds until ACK.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (!STALL) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ACK) begin
                    w_state_nxt = STALL ? ST_IDLE : ST_REQ;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // Datapath next values: PC selection, pending redirect, squash flag.
    always_comb begin
        w_pc_nxt         = r_pc;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_addr_nxt  = r_pend_addr;
        w_squash_nxt     = 1'b0;
        case (r_state)
            ST_BOOT, ST_IDLE: begin
                // No fetch in flight, so a redirect just moves the PC.
                if (REDIR) begin
                    w_pc_nxt = w_redir_addr;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_REQ: begin
                if (ACK) begin
                    // Same-cycle redirect beats a parked one, which beats +INC.
                    if (REDIR) begin
                        w_pc_nxt = w_redir_addr;
                    end else if (r_pend_valid) begin
                        w_pc_nxt = r_pend_addr;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                    w_squash_nxt     = REDIR | r_pend_valid;
                    w_pend_valid_nxt = 1'b0;
                end else begin
                    // ADDR must stay stable, so park the redirect instead.
                    if (REDIR) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_addr_nxt  = w_redir_addr;
                    end else begin
                        w_pend_valid_nxt = r_pend_valid;
                    end
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= {XLEN{1'b0}};
            r_squash     <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
            r_squash     <= w_squash_nxt;
        end
    end

    // Outputs are direct decodes of registers.
    always_comb begin
        REQ    = (r_state == ST_REQ);
        ADDR   = r_pc;
        SQUASH = r_squash;
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Self-checking bench for pc_fetch_seq: a transaction-level model predicts
// REQ/ADDR/SQUASH every cycle, and directed steps pin literal values.
module tb_pc_fetch_seq;

    logic        CLK = 1'b0;
    logic        RN = 1'b0;
    logic        STALL = 1'b0;
    logic        REDIR = 1'b0;
    logic [31:0] REDIR_ADDR = 32'h0;
    logic        ACK = 1'b0;
    logic        REQ;
    logic [31:0] ADDR;
    logic        SQUASH;

    int n_pass  = 0;
    int n_total = 0;

    pc_fetch_seq dut (
        .CLK        (CLK),
        .RN         (RN),
        .STALL      (STALL),
        .REDIR      (REDIR),
        .REDIR_ADDR (REDIR_ADDR),
        .REQ        (REQ),
        .ADDR       (ADDR),
        .ACK        (ACK),
        .SQUASH     (SQUASH)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: a fetch is either outstanding or not; redirects arriving during
    // an outstanding fetch queue up and the newest one counts.
    logic [31:0] m_pc       = 32'h0;
    bit          m_booted   = 1'b0;
    bit          m_fetching = 1'b0;
    bit          m_squash   = 1'b0;
    logic [31:0] m_pend[$];

    always @(negedge RN) begin
        m_pc       = 32'h0;
        m_booted   = 1'b0;
        m_fetching = 1'b0;
        m_squash   = 1'b0;
        m_pend.delete();
    end

    always @(posedge CLK) begin
        if (RN) begin
            bit nsq;
            nsq = 1'b0;
            if (!m_fetching) begin
                if (REDIR) m_pc = REDIR_ADDR & 32'hFFFF_FFFC;
                m_fetching = m_booted && !STALL;
                m_booted   = 1'b1;
            end else if (ACK) begin
                nsq = REDIR || (m_pend.size() > 0);
                if (REDIR)                 m_pc = REDIR_ADDR & 32'hFFFF_FFFC;
                else if (m_pend.size() > 0) m_pc = m_pend[$];
                else                        m_pc = m_pc + 32'd4;
                m_pend.delete();
                m_fetching = !STALL;
            end else if (REDIR) begin
                m_pend.push_back(REDIR_ADDR & 32'hFFFF_FFFC);
            end
            m_squash = nsq;
        end
    end

    // Compare every cycle, mid-period.
    always @(negedge CLK) begin
        check("model_req", {31'd0, REQ}, {31'd0, m_fetching});
        check("model_addr", ADDR, m_pc);
        check("model_squash", {31'd0, SQUASH}, {31'd0, m_squash});
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        // Reset release, ACK tied high.
        ACK = 1'b1;
        cyc(); cyc();
        check("rst_req", {31'd0, REQ}, 32'd0);
        check("rst_addr", ADDR, 32'h0);
        RN = 1'b1;
        cyc();
        check("boot_req", {31'd0, REQ}, 32'd0);
        cyc();
        check("req_rise", {31'd0, REQ}, 32'd1);
        check("addr0", ADDR, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("seq_addr", ADDR, 32'(i * 4));
            check("seq_squash", {31'd0, SQUASH}, 32'd0);
        end

        // ACK withheld 3 cycles with STALL toggling.
        ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            STALL = (i % 2 == 0);
            cyc();
            check("hold_req", {31'd0, REQ}, 32'd1);
            check("hold_addr", ADDR, 32'h10);
        end
        STALL = 1'b0; ACK = 1'b1;
        cyc();
        check("adv_addr", ADDR, 32'h14);

        // Redirect parked while ACK low, acked two cycles later.
        ACK = 1'b0; REDIR = 1'b1; REDIR_ADDR = 32'h200;
        cyc();
        check("park_addr", ADDR, 32'h14);
        REDIR = 1'b0;
        cyc();
        check("park_sq", {31'd0, SQUASH}, 32'd0);
        ACK = 1'b1;
        cyc();
        check("pend_addr", ADDR, 32'h200);
        check("pend_sq", {31'd0, SQUASH}, 32'd1);
        cyc();
        check("pend_next", ADDR, 32'h204);
        check("pend_sq_end", {31'd0, SQUASH}, 32'd0);

        // Pending 0x100 overtaken by same-cycle redirect 0x300.
        ACK = 1'b0; REDIR = 1'b1; REDIR_ADDR = 32'h100;
        cyc();
        ACK = 1'b1; REDIR_ADDR = 32'h300;
        cyc();
        check("win_addr", ADDR, 32'h300);
        check("win_sq", {31'd0, SQUASH}, 32'd1);
        ACK = 1'b0; REDIR = 1'b0;
        cyc();
        check("win_sq_end", {31'd0, SQUASH}, 32'd0);

        // Drop to IDLE, then unaligned redirect in IDLE with ignored ACK.
        ACK = 1'b1; STALL = 1'b1;
        cyc();
        check("idle_req", {31'd0, REQ}, 32'd0);
        check("idle_addr", ADDR, 32'h304);
        REDIR = 1'b1; REDIR_ADDR = 32'h203;
        cyc();
        check("mask_addr", ADDR, 32'h200);
        check("idle_sq", {31'd0, SQUASH}, 32'd0);
        REDIR = 1'b0; STALL = 1'b0;
        cyc();
        check("idle_to_req", {31'd0, REQ}, 32'd1);

        // Wrap through the top of the address space.
        REDIR = 1'b1; REDIR_ADDR = 32'hFFFF_FFFC;
        cyc();
        check("wrap_pre", ADDR, 32'hFFFF_FFFC);
        REDIR = 1'b0;
        cyc();
        check("wrap_addr", ADDR, 32'h0);

        // Reset mid-request with a parked redirect.
        ACK = 1'b0; REDIR = 1'b1; REDIR_ADDR = 32'h500;
        cyc();
        REDIR = 1'b0;
        RN = 1'b0;
        #1;
        check("async_req", {31'd0, REQ}, 32'd0);
        cyc();
        RN = 1'b1; ACK = 1'b1;
        cyc();
        check("reboot_req", {31'd0, REQ}, 32'd0);
        cyc();
        check("reboot_addr", ADDR, 32'h0);
        cyc();
        check("reboot_next", ADDR, 32'h4);
        check("reboot_sq", {31'd0, SQUASH}, 32'd0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
